// File: rtl/byte_serial_adder64.sv
// 64-bit adder built from one 8-bit ripple-carry stage reused across eight byte lanes.
// Operands are latched on start; one byte is added per cycle with the carry kept in a register.

module rca8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[8];
  end

endmodule

module byte_serial_adder64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  idx;
  logic [63:0] a_reg, b_reg, psum;
  logic        carry_reg;

  logic [7:0]  a_slice, b_slice, rca_s;
  logic        rca_c;
  logic        last;

  assign a_slice = a_reg[{idx, 3'b000} +: 8];
  assign b_slice = b_reg[{idx, 3'b000} +: 8];
  assign last    = (idx == 3'd7);

  rca8 u_rca (
    .x  (a_slice),
    .y  (b_slice),
    .ci (carry_reg),
    .s  (rca_s),
    .co (rca_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      psum      <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        idx       <= '0;
      end else if (state == RUN) begin
        psum[{idx, 3'b000} +: 8] <= rca_s;
        carry_reg <= rca_c;
        idx       <= idx + 3'd1;
        if (last) begin
          // byte 7 comes straight from the stage; psum has not captured it yet
          sum      <= {rca_s, psum[55:0]};
          cout     <= rca_c;
          overflow <= a_reg[63] ^ b_reg[63] ^ rca_s[7] ^ rca_c;
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_byte_serial_adder64.sv
// Directed and random checks of the byte-serial 64-bit adder against a 65-bit reference sum.

`timescale 1ns/1ps

module tb_byte_serial_adder64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] a, b;
  logic        cin;
  logic [63:0] sum;
  logic        cout, overflow, busy, done;

  int errors = 0;
  int checks = 0;

  byte_serial_adder64 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: unsigned 65-bit add, signed overflow from operand/result signs
  task automatic model(input logic [63:0] x, input logic [63:0] y, input logic ci,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] full;
    full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    s    = full[63:0];
    co   = full[64];
    ov   = (x[63] == y[63]) && (s[63] != x[63]);
  endtask

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic ci,
                        input logic [63:0] es, input logic eco, input logic eov);
    int k;
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    a = '1; b = '1; cin = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!done && k < 20);
    check("latency", 64'(k), 64'd8);
    check("sum", sum, es);
    check("cout", {63'd0, cout}, {63'd0, eco});
    check("overflow", {63'd0, overflow}, {63'd0, eov});
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] es, prev;
    logic        eco, eov;
    int          dones;
    logic        stable;

    vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 64'h0000_0000_0000_0008, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};
    vecs[5] = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 64'h0100_0100_0100_0100, 1'b0, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("reset_sum", sum, 64'd0);
    check("reset_flags", {59'd0, cout, overflow, busy, done, 1'b0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov);

    // Start while busy: second request is dropped, previous result holds until completion
    prev = sum;
    @(negedge clk);
    a = 64'h1000_0000_0000_0001; b = 64'h2000_0000_0000_0002; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; stable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (n < 8 && sum !== prev) stable = 1'b0;
      if (n == 2) begin
        a = 64'h5555_5555_5555_5555; b = 64'h3333_3333_3333_3333; cin = 1'b0; start = 1'b1;
      end
      if (n == 3) start = 1'b0;
      if (n == 8) begin
        check("busy_start_done", {63'd0, done}, 64'd1);
        check("busy_start_sum", sum, 64'h3000_0000_0000_0004);
      end
    end
    check("busy_start_prev_held", {63'd0, stable}, 64'd1);
    check("busy_start_one_done", 64'(dones), 64'd1);

    // Reset mid-operation at idx=4
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0F0F_0F0F_0F0F_0F0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_sum", sum, 64'd0);
    check("midreset_flags", {60'd0, cout, overflow, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);

    // Back-to-back with start held: each iteration spans exactly 10 edges
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra, rb;
      logic        rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = ~ra;
      a = ra; b = rb; cin = rc;
      model(ra, rb, rc, es, eco, eov);
      @(posedge clk); #1;
      check("b2b_accept", {63'd0, busy}, 64'd1);
      a = ~ra; b = 64'(i); cin = ~rc;
      repeat (8) @(posedge clk);
      #1;
      check("b2b_done", {63'd0, done}, 64'd1);
      check("b2b_sum", sum, es);
      check("b2b_flags", {62'd0, cout, overflow}, {62'd0, eco, eov});
      @(posedge clk); #1;
      check("b2b_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_serial_adder64.md
# byte_serial_adder64

Multi-cycle 64-bit adder that time-multiplexes a single 8-bit ripple-carry adder stage across the eight byte lanes of its operands. It sits directly upstream of the 8-bit RCA and owns the sequencing around it: it latches the operands, feeds one byte slice per cycle, registers the inter-byte carry, and collects the sum bytes. It is the area-reduced alternative to the fully unrolled 64-bit RCA in the adder suite and exposes a start/done handshake to the surrounding datapath.

## Interface
- Parameters: none. Width is fixed at 64 bits, slice at 8 bits, and byte count at 8.
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  64  operand A; sampled on the edge that accepts start
- b  input  64  operand B; sampled on the edge that accepts start
- cin  input  1  carry into bit 0; sampled on the edge that accepts start
- sum  output  64  registered result; holds until the next completion
- cout  output  1  carry out of bit 63
- overflow  output  1  two's-complement signed overflow of the 64-bit add
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, high in DONE

## Operation
- States are IDLE, RUN, and DONE. Encoding is free.
- **IDLE.** If start=1 at an edge:
  - latch a and b into operand registers and load the carry register with cin;
  - set byte index idx=0 and go to RUN.
  - If start=0, stay in IDLE.
- **RUN.** Each edge:
  - drive the 8-bit RCA with a_reg[8*idx+7:8*idx], b_reg[8*idx+7:8*idx], and carry_reg;
  - write the RCA sum into the partial-sum byte idx and load the RCA carry-out into carry_reg;
  - increment idx.
- **Leaving RUN.** On the edge that processes idx=7:
  - load sum from the complete partial-sum value, with byte 7 taken from this cycle's RCA output;
  - set cout to the RCA carry-out and set overflow to c63 XOR cout. c63 is the carry into bit 63: a_reg[63]^b_reg[63]^sum_byte7[7].
  - go to DONE.
- **DONE.** Lasts exactly one cycle, then goes to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. Operand inputs are don't-care outside the accepting edge.
- Exactly one 8-bit RCA instance is used. The carry chain between bytes passes only through carry_reg, with no combinational path across bytes.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^65.
- **Reset.** The asynchronous reset takes effect immediately, in any state:
  - state=IDLE, idx=0, carry_reg=0, and operand and partial-sum registers 0;
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - A reset during RUN aborts the operation and produces no done pulse.
  - After rst deasserts, the first start is accepted normally.

## Timing
- Acceptance edge E0 is the edge where start=1 in IDLE. busy rises after E0.
- Edges E1..E8 process bytes 0..7.
- After E8, done=1 and sum, cout, and overflow are valid. done falls after E9, and the block is back in IDLE.
- Latency from acceptance to done is 8 cycles.
- The earliest next acceptance is E10 (start high during the cycle after done), so peak throughput is one add per 10 cycles.
- sum, cout, and overflow change only on the completion edge or on reset. They stay stable while the next operation is in RUN.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Basic add.** a=0x0000_0000_0000_0005, b=0x0000_0000_0000_0003, cin=0. Required: after 8 cycles done=1, sum=0x8, cout=0, overflow=0, and done stays high for exactly 1 cycle.
- **Full ripple across all bytes.** a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1. Required: sum=0, cout=1, overflow=0.
- **Signed overflow.** a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0. Required: sum=0x8000_0000_0000_0000, cout=0, overflow=1.
  - a=b=0x8000_0000_0000_0000. Required: sum=0, cout=1, overflow=1.
- **Start while busy.** Pulse start 3 cycles after acceptance with different operands. Required: the result matches the first operands only, and only one done pulse occurs. A previous result stays on sum until the completion edge.
- **Reset mid-operation.** Assert rst asynchronously at idx=4. Required: all outputs are 0 immediately and no done pulse occurs. A new start with a=0x0123_4567_89AB_CDEF, b=0x1111_1111_1111_1111, cin=0 then gives sum=0x1234_5678_9ABC_DF00, cout=0.
- **Back-to-back.** Hold start=1 continuously. Required: acceptances occur every 10 cycles, and each result is correct against a reference a+b+cin model over 1000 random vectors.
